// File: rtl/core_if_pc_gen_pkg.sv
// Shared widths, reset PC and fetch FSM state encodings for the IF PC generator.
// The HALT encoding exists only when CORE_PC_MISALIGN_CHK_EN is defined.
package core_if_pc_gen_pkg;

  localparam int          CORE_PC_WIDTH   = 32;
  localparam int          CORE_INST_WIDTH = 32;
  localparam logic [31:0] CORE_RESET_PC   = 32'h8000_0000;

  typedef enum logic [2:0] {
    CORE_IF_ST_BOOT = 3'd0,
    CORE_IF_ST_REQ  = 3'd1,
    CORE_IF_ST_WAIT = 3'd2,
    CORE_IF_ST_DROP = 3'd3,
    CORE_IF_ST_OUT  = 3'd4
`ifdef CORE_PC_MISALIGN_CHK_EN
    ,
    CORE_IF_ST_HALT = 3'd5
`endif
  } if_state_e;

endpackage

// File: rtl/core_if_inst_buf.sv
// One-entry {pc, inst} holding register between fetch and decode.
// Load wins over clear; clearing drops only the valid bit.
module core_if_inst_buf #(
  parameter int PC_WIDTH   = 32,
  parameter int INST_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic                  i_clear,
  input  logic [PC_WIDTH-1:0]   i_pc,
  input  logic [INST_WIDTH-1:0] i_inst,
  output logic                  o_valid,
  output logic [PC_WIDTH-1:0]   o_pc,
  output logic [INST_WIDTH-1:0] o_inst
);

  logic                  r_valid;
  logic [PC_WIDTH-1:0]   r_pc;
  logic [INST_WIDTH-1:0] r_inst;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_inst  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_inst  <= i_inst;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_inst  = r_inst;

endmodule

// File: rtl/core_if_pc_gen.sv
// Fetch PC generator: one outstanding imem request, one-entry IF/ID buffer, EX redirect/flush.
// Define CORE_PC_MISALIGN_CHK_EN to trap bit-1 targets (sticky misalign_o, FSM parks in HALT).
module core_if_pc_gen
  import core_if_pc_gen_pkg::*;
#(
  parameter int                  PC_WIDTH   = CORE_PC_WIDTH,
  parameter int                  INST_WIDTH = CORE_INST_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = PC_WIDTH'(CORE_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  input  logic                  ex_branch_jump,
  input  logic [PC_WIDTH-1:0]   ex_bj_pc,
  output logic                  ifu_req_valid,
  output logic [PC_WIDTH-1:0]   ifu_req_addr,
  input  logic                  ifu_req_ready,
  input  logic                  ifu_rsp_valid,
  input  logic [INST_WIDTH-1:0] ifu_rsp_inst,
  output logic                  if_id_valid,
  output logic [PC_WIDTH-1:0]   if_id_pc,
  output logic [INST_WIDTH-1:0] if_id_inst,
  input  logic                  if_id_ready,
  output logic                  flush_o
`ifdef CORE_PC_MISALIGN_CHK_EN
  ,
  output logic                  misalign_o
`endif
);

  if_state_e             r_state;
  if_state_e             w_state_next;
  logic [PC_WIDTH-1:0]   r_pc;
  logic [PC_WIDTH-1:0]   w_pc_next;
  logic [PC_WIDTH-1:0]   w_tgt;
  logic                  w_redirect;
  logic                  w_jump;
  logic                  w_buf_load;
  logic                  w_buf_clear;
  logic                  w_unused_bj;

  assign w_redirect  = ex_valid & ex_branch_jump;
  assign flush_o     = w_redirect;
  assign w_unused_bj = ^ex_bj_pc[1:0];

`ifdef CORE_PC_MISALIGN_CHK_EN
  logic w_misalign_hit;
  logic r_misalign;

  // A bit-1 target is trapped instead of followed.
  assign w_misalign_hit = w_redirect & ex_bj_pc[1];
  assign w_jump         = w_redirect & ~ex_bj_pc[1];
  assign w_tgt          = {ex_bj_pc[PC_WIDTH-1:1], 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_misalign <= 1'b0;
    end else if (w_misalign_hit) begin
      r_misalign <= 1'b1;
    end
  end

  assign misalign_o = r_misalign;
`else
  assign w_jump = w_redirect;
  assign w_tgt  = {ex_bj_pc[PC_WIDTH-1:2], 2'b00};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= CORE_IF_ST_BOOT;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
    end
  end

  // Redirect outranks every handshake in every state.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_buf_load   = 1'b0;
    w_buf_clear  = 1'b0;
    case (r_state)
      CORE_IF_ST_BOOT: begin
        if (w_jump) w_pc_next = w_tgt;
        w_state_next = CORE_IF_ST_REQ;
      end
      CORE_IF_ST_REQ: begin
        if (w_jump) begin
          w_pc_next    = w_tgt;
          w_state_next = ifu_req_ready ? CORE_IF_ST_DROP : CORE_IF_ST_REQ;
        end else if (ifu_req_ready) begin
          w_state_next = CORE_IF_ST_WAIT;
        end
      end
      CORE_IF_ST_WAIT: begin
        if (w_jump) begin
          w_pc_next    = w_tgt;
          w_state_next = ifu_rsp_valid ? CORE_IF_ST_REQ : CORE_IF_ST_DROP;
        end else if (ifu_rsp_valid) begin
          w_buf_load   = 1'b1;
          w_pc_next    = r_pc + PC_WIDTH'(4);
          w_state_next = CORE_IF_ST_OUT;
        end
      end
      CORE_IF_ST_DROP: begin
        // A response arriving here belongs to the abandoned request.
        if (w_jump) w_pc_next = w_tgt;
        if (ifu_rsp_valid) w_state_next = CORE_IF_ST_REQ;
      end
      CORE_IF_ST_OUT: begin
        if (w_jump) begin
          w_buf_clear  = 1'b1;
          w_pc_next    = w_tgt;
          w_state_next = CORE_IF_ST_REQ;
        end else if (if_id_ready) begin
          w_buf_clear  = 1'b1;
          w_state_next = CORE_IF_ST_REQ;
        end
      end
`ifdef CORE_PC_MISALIGN_CHK_EN
      CORE_IF_ST_HALT: w_state_next = CORE_IF_ST_HALT;
`endif
      default: w_state_next = CORE_IF_ST_BOOT;
    endcase
`ifdef CORE_PC_MISALIGN_CHK_EN
    if (w_misalign_hit) begin
      w_state_next = CORE_IF_ST_HALT;
      w_pc_next    = r_pc;
      w_buf_load   = 1'b0;
      w_buf_clear  = 1'b1;
    end
`endif
  end

  always_comb begin
    ifu_req_valid = (r_state == CORE_IF_ST_REQ);
    ifu_req_addr  = r_pc;
  end

  core_if_inst_buf #(
    .PC_WIDTH   (PC_WIDTH),
    .INST_WIDTH (INST_WIDTH)
  ) u_inst_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_buf_load),
    .i_clear (w_buf_clear),
    .i_pc    (r_pc),
    .i_inst  (ifu_rsp_inst),
    .o_valid (if_id_valid),
    .o_pc    (if_id_pc),
    .o_inst  (if_id_inst)
  );

endmodule

// File: tb/tb_core_if_pc_gen.sv
// Directed bench for core_if_pc_gen: memory model plus {pc, inst} scoreboard queue.
// Build with +define+CORE_PC_MISALIGN_CHK_EN to exercise the misalignment trap.
module tb_core_if_pc_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ex_valid = 1'b0;
  logic        ex_branch_jump = 1'b0;
  logic [31:0] ex_bj_pc = '0;
  logic        ifu_req_valid;
  logic [31:0] ifu_req_addr;
  logic        ifu_req_ready = 1'b0;
  logic        ifu_rsp_valid = 1'b0;
  logic [31:0] ifu_rsp_inst = '0;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_inst;
  logic        if_id_ready = 1'b0;
  logic        flush_o;
`ifdef CORE_PC_MISALIGN_CHK_EN
  logic        misalign_o;
`endif

  core_if_pc_gen dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_valid       (ex_valid),
    .ex_branch_jump (ex_branch_jump),
    .ex_bj_pc       (ex_bj_pc),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_addr   (ifu_req_addr),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_rsp_valid  (ifu_rsp_valid),
    .ifu_rsp_inst   (ifu_rsp_inst),
    .if_id_valid    (if_id_valid),
    .if_id_pc       (if_id_pc),
    .if_id_inst     (if_id_inst),
    .if_id_ready    (if_id_ready),
    .flush_o        (flush_o)
`ifdef CORE_PC_MISALIGN_CHK_EN
    ,
    .misalign_o     (misalign_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int cyc    = 0;
  int delivered = 0;
  int deliv_cyc[$];
  logic [63:0] sb[$];

  // memory model state
  logic        mem_ready = 1'b1;
  logic        mem_auto  = 1'b1;
  logic        force_rsp = 1'b0;
  logic        id_ready  = 1'b1;
  logic        pend      = 1'b0;
  logic [31:0] pend_addr = '0;
  int          pend_cnt  = 0;
  int          rsp_lat   = 1;

  // snapshots taken mid-cycle
  logic        s_req_valid, s_if_id_valid, s_flush, s_acc, s_misalign;
  logic [31:0] s_req_addr, s_if_id_pc, s_if_id_inst;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    sb.push_back({pc, mem_data(pc)});
  endtask

  task automatic step(input logic redir = 1'b0, input logic [31:0] tgt = 32'h0,
                      input logic bj_only = 1'b0);
    logic [63:0] e;
    @(negedge clk);
    ex_valid       = redir;
    ex_branch_jump = redir | bj_only;
    ex_bj_pc       = tgt;
    ifu_req_ready  = mem_ready;
    if_id_ready    = id_ready;
    ifu_rsp_valid  = 1'b0;
    ifu_rsp_inst   = '0;
    if (pend) begin
      if (force_rsp || (mem_auto && pend_cnt <= 1)) begin
        ifu_rsp_valid = 1'b1;
        ifu_rsp_inst  = mem_data(pend_addr);
        pend      = 1'b0;
        force_rsp = 1'b0;
      end else if (mem_auto) begin
        pend_cnt--;
      end
    end
    #1;
    s_req_valid   = ifu_req_valid;
    s_req_addr    = ifu_req_addr;
    s_if_id_valid = if_id_valid;
    s_if_id_pc    = if_id_pc;
    s_if_id_inst  = if_id_inst;
    s_flush       = flush_o;
`ifdef CORE_PC_MISALIGN_CHK_EN
    s_misalign    = misalign_o;
`else
    s_misalign    = 1'b0;
`endif
    s_acc = ifu_req_valid & ifu_req_ready;
    if (s_acc) begin
      pend      = 1'b1;
      pend_addr = ifu_req_addr;
      pend_cnt  = rsp_lat;
    end
    if (if_id_valid && if_id_ready) begin
      $display("cyc %0d deliver pc=%h inst=%h", cyc, if_id_pc, if_id_inst);
      delivered++;
      deliv_cyc.push_back(cyc);
      checks++;
      assert (sb.size() != 0) passes++;
      else begin
        fails++;
        $error("FAIL sb_unexpected: observed pc=%h expected no delivery", if_id_pc);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("sb_pc", if_id_pc, e[63:32]);
        check("sb_inst", if_id_inst, e[31:0]);
      end
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic wait_deliv(input int n, input int budget, input string tag);
    int target;
    int k;
    target = delivered + n;
    k = 0;
    while (delivered < target && k < budget) begin
      step();
      k++;
    end
    check(tag, delivered, target);
    check({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  task automatic step_to_accept(input string tag);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (!s_acc && k < 10);
    check(tag, s_acc, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    int thr;
    #1 rst_n = 1'b0;
    // reset state
    step();
    step();
    check("rst_req_valid", s_req_valid, 0);
    check("rst_req_addr", s_req_addr, 32'h8000_0000);
    check("rst_if_id_valid", s_if_id_valid, 0);
    check("rst_if_id_pc", s_if_id_pc, 0);
    check("rst_if_id_inst", s_if_id_inst, 0);
    check("rst_flush", s_flush, 0);

    // 1: sequential fetch
    push_exp(32'h8000_0000);
    push_exp(32'h8000_0004);
    push_exp(32'h8000_0008);
    #2 rst_n = 1'b1;
    step();
    check("t1_boot_idle", s_req_valid, 0);
    step();
    check("t1_req_valid", s_req_valid, 1);
    check("t1_req_addr", s_req_addr, 32'h8000_0000);
    wait_deliv(3, 20, "t1_deliv");
    thr = (deliv_cyc.size() >= 3) ? (deliv_cyc[2] - deliv_cyc[0]) : -1;
    check("t1_throughput", thr, 6);

    // 2: redirect in WAIT, late response must be dropped
    mem_auto = 1'b0;
    step_to_accept("t2_accept");
    step(1'b1, 32'h8000_0100);
    check("t2_flush", s_flush, 1);
    step();
    check("t2_flush_once", s_flush, 0);
    check("t2_drop_no_req", s_req_valid, 0);
    force_rsp = 1'b1;
    step();
    check("t2_late_rsp_no_valid", s_if_id_valid, 0);
    step();
    check("t2_req_valid", s_req_valid, 1);
    check("t2_req_addr", s_req_addr, 32'h8000_0100);
    check("t2_no_old_valid", s_if_id_valid, 0);
    mem_auto = 1'b1;
    pend_cnt = 1;
    push_exp(32'h8000_0100);
    wait_deliv(1, 10, "t2_deliv");

    // 3: redirect coincident with response
    step_to_accept("t3_accept");
    step(1'b1, 32'h8000_0200);
    check("t3_flush", s_flush, 1);
    step();
    check("t3_req_valid", s_req_valid, 1);
    check("t3_req_addr", s_req_addr, 32'h8000_0200);
    check("t3_no_old_valid", s_if_id_valid, 0);
    push_exp(32'h8000_0200);
    wait_deliv(1, 10, "t3_deliv");

    // 4: decode stall in OUT
    id_ready = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (!s_if_id_valid && n < 10);
    check("t4_reach_out", s_if_id_valid, 1);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) step(1'b0, 32'h8000_0900, 1'b1);
      else if (k > 0) step();
      check("t4_stall_pc", s_if_id_pc, 32'h8000_0204);
      check("t4_stall_inst", s_if_id_inst, mem_data(32'h8000_0204));
      check("t4_stall_no_req", s_req_valid, 0);
      check("t4_stall_no_flush", s_flush, 0);
    end
    id_ready = 1'b1;
    push_exp(32'h8000_0204);
    step();
    check("t4_sb_drained", sb.size(), 0);

    // 5: pc+4 after the next request, then wrap from FFFF_FFFC
    step(1'b1, 32'hFFFF_FFFC);
    check("t4_next_req_valid", s_req_valid, 1);
    check("t4_next_req_addr", s_req_addr, 32'h8000_0208);
    check("t5_flush", s_flush, 1);
    push_exp(32'hFFFF_FFFC);
    push_exp(32'h0000_0000);
    wait_deliv(2, 20, "t5_wrap_deliv");

    // redirect before acceptance retargets the pending request
    mem_ready = 1'b0;
    step(1'b1, 32'h8000_0300);
    check("t5b_req_addr_before", s_req_addr, 32'h0000_0004);
    step();
    check("t5b_req_valid", s_req_valid, 1);
    check("t5b_req_addr", s_req_addr, 32'h8000_0300);

    // 6: bit-1 target
    step(1'b1, 32'h8000_0102);
    check("t6_flush", s_flush, 1);
`ifdef CORE_PC_MISALIGN_CHK_EN
    mem_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("t6_misalign", s_misalign, 1);
      check("t6_halt_no_req", s_req_valid, 0);
      check("t6_halt_no_valid", s_if_id_valid, 0);
    end
`else
    step();
    check("t6_req_valid", s_req_valid, 1);
    check("t6_req_addr", s_req_addr, 32'h8000_0100);
    mem_ready = 1'b1;
    push_exp(32'h8000_0100);
    wait_deliv(1, 10, "t6_deliv");
    step_to_accept("t7_accept");
`endif

    // 7: reset mid-transaction, then flush in BOOT
    #2 rst_n = 1'b0;
    pend = 1'b0;
    step();
    check("t7_rst_req_valid", s_req_valid, 0);
    check("t7_rst_if_id_valid", s_if_id_valid, 0);
    check("t7_rst_if_id_pc", s_if_id_pc, 0);
    check("t7_rst_req_addr", s_req_addr, 32'h8000_0000);
    check("t7_rst_misalign", s_misalign, 0);
    step();
    #2 rst_n = 1'b1;
    step(1'b1, 32'h8000_0400);
    check("t7_boot_flush", s_flush, 1);
    check("t7_boot_no_req", s_req_valid, 0);
    step();
    check("t7_req_after_boot", s_req_valid, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
